// File: rtl/yarp_regfile_mp.sv
// Multi-read-port register file with two prioritised write ports and a post-reset zeroing sequencer.
// Optional macro YARP_REGFILE_BYPASS_EN forwards same-cycle write data to colliding reads.
module yarp_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_addr_i,
  input  logic [XLEN-1:0]          wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_addr_i,
  input  logic [XLEN-1:0]          wr1_data_i,
  output logic                     init_busy_o
);

  // state   | meaning
  // S_INIT  | zeroing entries 1..NUM_REGS-1, one per cycle; ports ignored
  // S_READY | normal read/write operation until the next reset
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]              r_state;
  logic [ADDR_W-1:0]       r_init_cnt;
  logic                    r_init_busy;
  logic [XLEN-1:0]         r_mem [1:NUM_REGS-1];
  logic [NUM_RD*XLEN-1:0]  r_rd_data;
  logic [NUM_RD-1:0]       r_rd_valid;

  logic                    w_ready;
  logic                    w_wr0_ok;
  logic                    w_wr1_ok;
  logic [XLEN-1:0]         w_rd_val [NUM_RD];

  assign w_ready  = (r_state == S_READY);
  assign w_wr0_ok = w_ready && wr0_en_i && (wr0_addr_i != '0) &&
                    ({1'b0, wr0_addr_i} < (ADDR_W+1)'(NUM_REGS));
  assign w_wr1_ok = w_ready && wr1_en_i && (wr1_addr_i != '0) &&
                    ({1'b0, wr1_addr_i} < (ADDR_W+1)'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_init_cnt  <= ADDR_W'(1);
      r_init_busy <= 1'b1;
    end else if (r_state == S_INIT) begin
      if (r_init_cnt == ADDR_W'(NUM_REGS - 1)) begin
        r_state     <= S_READY;
        r_init_busy <= 1'b0;
      end
      r_init_cnt <= r_init_cnt + ADDR_W'(1);
    end
  end

  // Entry 0 is not stored; wr1 takes priority over wr0 on a shared address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (!w_ready && (r_init_cnt == ADDR_W'(i)))
          r_mem[i] <= '0;
        else if (w_wr1_ok && (wr1_addr_i == ADDR_W'(i)))
          r_mem[i] <= wr1_data_i;
        else if (w_wr0_ok && (wr0_addr_i == ADDR_W'(i)))
          r_mem[i] <= wr0_data_i;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_val[k] = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(i))
          w_rd_val[k] = r_mem[i];
      end
`ifdef YARP_REGFILE_BYPASS_EN
      if (w_wr0_ok && (wr0_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W]))
        w_rd_val[k] = wr0_data_i;
      if (w_wr1_ok && (wr1_addr_i == rd_addr_i[k*ADDR_W +: ADDR_W]))
        w_rd_val[k] = wr1_data_i;
`endif
    end
  end

  // Idle ports keep their last data; only valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else if (w_ready) begin
      r_rd_valid <= rd_en_i;
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_en_i[k])
          r_rd_data[k*XLEN +: XLEN] <= w_rd_val[k];
      end
    end else begin
      r_rd_valid <= '0;
    end
  end

  assign rd_data_o   = r_rd_data;
  assign rd_valid_o  = r_rd_valid;
  assign init_busy_o = r_init_busy;

endmodule

// File: tb/tb_yarp_regfile_mp.sv
// Directed bench for yarp_regfile_mp: default instance plus a NUM_REGS=24 / NUM_RD=3 instance.
module tb_yarp_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        wr0_en, wr1_en;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        busy;

  logic [2:0]  b_rd_en;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_valid;
  logic        b_wr0_en, b_wr1_en;
  logic [4:0]  b_wr0_addr, b_wr1_addr;
  logic [31:0] b_wr0_data, b_wr1_data;
  logic        b_busy;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  yarp_regfile_mp dut (
    .clk(clk), .reset(reset),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .init_busy_o(busy)
  );

  yarp_regfile_mp #(.XLEN(32), .NUM_REGS(24), .NUM_RD(3)) dut24 (
    .clk(clk), .reset(reset),
    .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid),
    .wr0_en_i(b_wr0_en), .wr0_addr_i(b_wr0_addr), .wr0_data_i(b_wr0_data),
    .wr1_en_i(b_wr1_en), .wr1_addr_i(b_wr1_addr), .wr1_data_i(b_wr1_data),
    .init_busy_o(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr0_en = 1'b0; wr1_en = 1'b0;
    b_rd_en = '0; b_wr0_en = 1'b0; b_wr1_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_en = '0; rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    b_rd_en = '0; b_rd_addr = '0;
    b_wr0_en = 1'b0; b_wr0_addr = '0; b_wr0_data = '0;
    b_wr1_en = 1'b0; b_wr1_addr = '0; b_wr1_data = '0;

    tick();
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_data", rd_data, 64'd0);
    reset = 1'b0;

    // Count INIT cycles, poking read and write ports part-way through.
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 3) begin
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
      end else begin
        idle();
      end
      if (n == 5) begin
        check("init_rd_valid", 64'(rd_valid), 64'd0);
        check("init_rd_data", rd_data, 64'd0);
      end
      tick();
    end
    idle();
    check("init_len", 64'(n), 64'd31);
    check("init_b24_busy", 64'(b_busy), 64'd0);

    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick(); idle();
    check("x5_dropped_valid", 64'(rd_valid), 64'd1);
    check("x5_dropped_data", 64'(rd_data[31:0]), 64'd0);

    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1234_5678;
    tick(); idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd7};
    tick(); idle();
    check("x7_valid", 64'(rd_valid), 64'd2);
    check("x7_data_p1", 64'(rd_data[63:32]), 64'h1234_5678);
    check("x7_p0_hold", 64'(rd_data[31:0]), 64'd0);

    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAAAA_AAAA;
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h5555_5555;
    tick(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    tick(); idle();
    check("x3_wr1_wins", 64'(rd_data[31:0]), 64'h5555_5555);

    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    tick(); idle();
    rd_en = 2'b10; rd_addr = {5'd0, 5'd3};
    tick(); idle();
    check("x0_reads_zero", 64'(rd_data[63:32]), 64'd0);

    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h0000_0010;
    wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h0000_0011;
    tick(); idle();
    rd_en = 2'b11; rd_addr = {5'd11, 5'd10};
    tick(); idle();
    check("dual_write", rd_data, {32'h0000_0011, 32'h0000_0010});

    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1;
    tick(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h2;
    tick(); idle();
`ifdef YARP_REGFILE_BYPASS_EN
    check("x9_collide", 64'(rd_data[31:0]), 64'h2);
`else
    check("x9_collide", 64'(rd_data[31:0]), 64'h1);
`endif
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    tick(); idle();
    check("x9_after", 64'(rd_data[31:0]), 64'h2);

    b_wr0_en = 1'b1; b_wr0_addr = 5'd30; b_wr0_data = 32'hCAFE_F00D;
    b_wr1_en = 1'b1; b_wr1_addr = 5'd4;  b_wr1_data = 32'h0000_0044;
    tick(); idle();
    b_rd_en = 3'b001; b_rd_addr = {5'd0, 5'd0, 5'd30};
    tick(); idle();
    check("b24_oor_valid", 64'(b_rd_valid), 64'd1);
    check("b24_oor_data", 64'(b_rd_data[31:0]), 64'd0);
    b_rd_en = 3'b111; b_rd_addr = {5'd4, 5'd4, 5'd4};
    tick(); idle();
    check("b24_x4_p0", 64'(b_rd_data[31:0]), 64'h44);
    check("b24_x4_p1", 64'(b_rd_data[63:32]), 64'h44);
    check("b24_x4_p2", 64'(b_rd_data[95:64]), 64'h44);

    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h77;
    tick(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd2};
    tick(); idle();
    check("x2_before_reset", 64'(rd_data[31:0]), 64'h77);

    reset = 1'b1;
    tick();
    check("rereset_data", rd_data, 64'd0);
    check("rereset_valid", 64'(rd_valid), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midinit_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("reinit_len", 64'(n), 64'd31);

    rd_en = 2'b01; rd_addr = {5'd0, 5'd2};
    tick(); idle();
    check("x2_after_reinit_valid", 64'(rd_valid), 64'd1);
    check("x2_after_reinit", 64'(rd_data[31:0]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/yarp_regfile_mp.md
Name: yarp_regfile_mp

Overview:
- Parametrised successor to the YARP single-issue register file.
- Configurable data width, depth and number of read ports; two prioritised write ports.
- Registered reads with per-port valid.
- After reset, a hardware init sequencer zeroes storage one entry per cycle.
- Target: dual-issue / superscalar YARP variants. Sits between the decode stage (read) and the writeback stage (write).

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers (2..64; need not be a power of 2).
- NUM_RD, 2, number of read ports (1..4).
- ADDR_W, $clog2(NUM_REGS), address width. Derived; must not be overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en_i  in  NUM_RD  per-port read request.
- rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*XLEN  packed registered read data; port k at bits [k*XLEN +: XLEN].
- rd_valid_o  out  NUM_RD  per-port read data valid.
- wr0_en_i  in  1  write port 0 enable (lower priority).
- wr0_addr_i  in  ADDR_W  write port 0 address.
- wr0_data_i  in  XLEN  write port 0 data.
- wr1_en_i  in  1  write port 1 enable (higher priority).
- wr1_addr_i  in  ADDR_W  write port 1 address.
- wr1_data_i  in  XLEN  write port 1 data.
- init_busy_o  out  1  high while the init sequencer runs.

Behaviour:
- Reset: synchronous, active-high, single clock clk.
  - On any cycle with reset=1: state <= INIT, init_cnt <= 1, rd_data_o <= 0, rd_valid_o <= 0, init_busy_o <= 1.
  - Reset does not directly clear storage.
- State machine, two states:
  - INIT: each cycle writes 0 to entry init_cnt and increments init_cnt. After the write of entry NUM_REGS-1, go to READY and drop init_busy_o.
  - READY: normal operation. Stays in READY until reset.
  - INIT lasts exactly NUM_REGS-1 cycles after reset deasserts (31 for the default).
  - Reset asserted mid-INIT or in READY restarts INIT at init_cnt=1.
- INIT side effects:
  - All write-port requests are dropped.
  - Read requests are ignored: rd_valid_o=0, rd_data_o holds 0.
- Entry 0:
  - Never stored; reads of address 0 always return 0.
  - Writes to address 0 are dropped.
- Write (READY only):
  - Entry updated on the edge where en=1, addr!=0 and addr<NUM_REGS.
  - Out-of-range addresses (addr>=NUM_REGS) are dropped silently.
  - Both ports to the same address in one cycle: wr1 data wins.
  - Different addresses: both written.
- Read (READY only):
  - Latency 1 cycle.
  - rd_valid_o[k] <= rd_en_i[k].
  - When rd_en_i[k]=1: rd_data_o[k] <= entry[rd_addr_i[k]]; address 0 or out-of-range gives 0.
  - When rd_en_i[k]=0: rd_data_o[k] holds its previous value.
  - Read ports are independent; several ports may read the same address.
- Read/write same address same cycle (no bypass): read returns the old (pre-write) value; the new value is visible from the next read.
- No X on any output after the first reset cycle.

Optional Feature:
- Macro: YARP_REGFILE_BYPASS_EN.
- Defined: a read colliding with a valid in-range nonzero write in the same cycle returns the write data. If both write ports match the read address, wr1 data is returned. Bypass is disabled during INIT.
- Not defined: read-old-value semantics as in Behaviour. No bypass muxes are synthesised.

Test Plan:
- Reset 1 cycle then release -> init_busy_o high for exactly 31 cycles (default params). A rd_en_i=2'b11 issued during INIT gives rd_valid_o=0. A write of 0xDEAD_BEEF to x5 during INIT is dropped; a later read of x5 returns 0.
- READY: write x7=0x1234_5678 via wr0; next cycle read port 1 of x7 -> one cycle later rd_valid_o[1]=1, data 0x1234_5678. Port 0 is idle and holds its data with valid=0.
- Same cycle: wr0 x3=0xAAAA_AAAA and wr1 x3=0x5555_5555 -> subsequent read of x3 = 0x5555_5555. Write to x0 of 0xFFFF_FFFF -> read x0 = 0.
- Same-cycle read and write of x9: old value 0x1, new value 0x2.
  - Without the macro: returns 0x1, next read returns 0x2.
  - With YARP_REGFILE_BYPASS_EN: returns 0x2.
- NUM_REGS=24, NUM_RD=3: write to address 30 is dropped; read of address 30 returns 0. All three ports reading x4 in one cycle return identical data.
- Assert reset at INIT cycle 10, hold 1 cycle -> init restarts, init_busy_o high 31 further cycles. Write x2=0x77 in READY, reassert reset -> after re-init x2 reads 0.
